// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types for the SDRAM port arbiter: FSM state encoding and grant codes.
// Grant codes equal the controller rw bit so the latched grant drives o_ctrl_rw directly.
package sdram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_XFER
  } arb_state_e;

  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

endpackage

// File: rtl/sdram_port_arbiter_burst_buffer.sv
// One-burst write staging buffer: filled word by word, drained by controller data strobes.
// Stays full from the filling push until the burst that drains it completes.
module sdram_burst_buffer #(
  parameter int WordLength  = 16,
  parameter int BurstLength = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic [WordLength-1:0] wdata,
  input  logic                  adv,
  input  logic                  clear,
  output logic                  full,
  output logic                  filling,
  output logic                  overflow,
  output logic [WordLength-1:0] rdata
);

  localparam int PW = (BurstLength > 1) ? $clog2(BurstLength) : 1;
  localparam int CW = $clog2(BurstLength + 1);

  logic [BurstLength-1:0][WordLength-1:0] mem;
  logic [PW-1:0]                          wr_ptr, rd_ptr;
  logic [CW-1:0]                          count;
  logic                                   accept;

  assign full    = (count == CW'(BurstLength));
  assign accept  = push && !full;
  assign filling = accept && (count == CW'(BurstLength - 1));
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mem      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (clear) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (accept) begin
          mem[wr_ptr] <= wdata;
          count       <= count + CW'(1);
          wr_ptr      <= (wr_ptr == PW'(BurstLength - 1)) ? '0 : wr_ptr + PW'(1);
        end
        // Extra strobes keep re-reading the last word rather than wrapping.
        if (adv && rd_ptr != PW'(BurstLength - 1))
          rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && full)
        overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates the single-user SDRAM controller between a burst-read port and a
// staged burst-write port; reads win unless the write buffer has been starved.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int WordLength   = 16,
  parameter int AddressWidth = 24,
  parameter int BurstLength  = 8,
  parameter int StarveLimit  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    i_rd_req,
  input  logic [AddressWidth-1:0] i_rd_addr,
  output logic                    o_rd_ack,
  output logic [WordLength-1:0]   o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_rd_done,
  input  logic                    i_wr_push,
  input  logic [WordLength-1:0]   i_wr_data,
  input  logic [AddressWidth-1:0] i_wr_addr,
  output logic                    o_wr_full,
  output logic                    o_wr_overflow,
  output logic                    o_wr_done,
  output logic                    o_ctrl_enable,
  output logic                    o_ctrl_rw,
  output logic [AddressWidth-1:0] o_ctrl_addr,
  output logic [WordLength-1:0]   o_ctrl_wdata,
  input  logic [WordLength-1:0]   i_ctrl_rdata,
  input  logic                    i_ctrl_valid,
  input  logic                    i_ctrl_busy
);

  localparam int SW = $clog2(StarveLimit + 1);
  localparam int CW = $clog2(BurstLength + 1);

  arb_state_e              state, state_nx;
  logic                    grant_q;
  logic [AddressWidth-1:0] addr_q, wr_addr_q;
  logic [SW-1:0]           starve_q;
  logic [CW-1:0]           beat_cnt;
  logic                    rd_valid_q, rd_done_q, wr_done_q;
  logic [WordLength-1:0]   rd_data_q;
  logic                    start, finish, pick_wr, rd_fwd;
  logic                    buf_full, buf_filling, buf_adv, buf_clear;

  assign pick_wr = buf_full && (!i_rd_req || starve_q >= SW'(StarveLimit));
  assign rd_fwd  = (state == ST_XFER) && (grant_q == GRANT_RD) && i_ctrl_valid
                   && (beat_cnt < CW'(BurstLength));
  assign buf_adv   = (state == ST_XFER) && (grant_q == GRANT_WR) && i_ctrl_valid;
  assign buf_clear = finish && (grant_q == GRANT_WR);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    finish   = 1'b0;
    case (state)
      ST_IDLE:
        if (!i_ctrl_busy && (i_rd_req || buf_full)) begin
          state_nx = ST_ISSUE;
          start    = 1'b1;
        end
      ST_ISSUE:     state_nx = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (i_ctrl_busy) state_nx = ST_XFER;
      ST_XFER:
        if (!i_ctrl_busy) begin
          state_nx = ST_IDLE;
          finish   = 1'b1;
        end
      default:      state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      grant_q    <= GRANT_WR;
      addr_q     <= '0;
      wr_addr_q  <= '0;
      starve_q   <= '0;
      beat_cnt   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_done_q  <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      if (start) begin
        grant_q <= pick_wr ? GRANT_WR : GRANT_RD;
        addr_q  <= pick_wr ? wr_addr_q : i_rd_addr;
        // Only reads that bypass a ready write buffer count towards starvation.
        if (pick_wr)
          starve_q <= '0;
        else if (buf_full && starve_q < SW'(StarveLimit))
          starve_q <= starve_q + SW'(1);
      end
      if (start)       beat_cnt <= '0;
      else if (rd_fwd) beat_cnt <= beat_cnt + CW'(1);
      if (buf_filling) wr_addr_q <= i_wr_addr;
      rd_valid_q <= rd_fwd;
      rd_data_q  <= rd_fwd ? i_ctrl_rdata : '0;
      rd_done_q  <= finish && (grant_q == GRANT_RD);
      wr_done_q  <= finish && (grant_q == GRANT_WR);
    end
  end

  sdram_burst_buffer #(
    .WordLength (WordLength),
    .BurstLength(BurstLength)
  ) u_buf (
    .CLK     (CLK),
    .RST     (RST),
    .push    (i_wr_push),
    .wdata   (i_wr_data),
    .adv     (buf_adv),
    .clear   (buf_clear),
    .full    (buf_full),
    .filling (buf_filling),
    .overflow(o_wr_overflow),
    .rdata   (o_ctrl_wdata)
  );

  assign o_ctrl_enable = (state == ST_ISSUE);
  assign o_rd_ack      = (state == ST_ISSUE) && (grant_q == GRANT_RD);
  assign o_ctrl_rw     = grant_q;
  assign o_ctrl_addr   = addr_q;
  assign o_rd_data     = rd_data_q;
  assign o_rd_valid    = rd_valid_q;
  assign o_rd_done     = rd_done_q;
  assign o_wr_done     = wr_done_q;
  assign o_wr_full     = buf_full;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized bench for sdram_port_arbiter: transaction-level model of the arbitration
// rules, staging buffer and a behavioural SDRAM controller, plus directed scenarios.
module tb_sdram_port_arbiter;

  localparam int WL = 16;
  localparam int AW = 24;
  localparam int BL = 8;
  localparam int SL = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          i_rd_req, o_rd_ack, o_rd_valid, o_rd_done;
  logic [AW-1:0] i_rd_addr, i_wr_addr, o_ctrl_addr;
  logic [WL-1:0] o_rd_data, i_wr_data, o_ctrl_wdata, i_ctrl_rdata;
  logic          i_wr_push, o_wr_full, o_wr_overflow, o_wr_done;
  logic          o_ctrl_enable, o_ctrl_rw, i_ctrl_valid, i_ctrl_busy;

  always #5 CLK = ~CLK;

  sdram_port_arbiter #(
    .WordLength(WL), .AddressWidth(AW), .BurstLength(BL), .StarveLimit(SL)
  ) dut (
    .CLK(CLK), .RST(RST),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .o_rd_ack(o_rd_ack),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_rd_done(o_rd_done),
    .i_wr_push(i_wr_push), .i_wr_data(i_wr_data), .i_wr_addr(i_wr_addr),
    .o_wr_full(o_wr_full), .o_wr_overflow(o_wr_overflow), .o_wr_done(o_wr_done),
    .o_ctrl_enable(o_ctrl_enable), .o_ctrl_rw(o_ctrl_rw), .o_ctrl_addr(o_ctrl_addr),
    .o_ctrl_wdata(o_ctrl_wdata), .i_ctrl_rdata(i_ctrl_rdata),
    .i_ctrl_valid(i_ctrl_valid), .i_ctrl_busy(i_ctrl_busy)
  );

  int checks = 0;
  int errors = 0;

  // model of the arbiter as seen from outside
  bit            free, exp_en, exp_rw, exp_rv, exp_rdone, exp_wdone, cur_rw, movf;
  logic [AW-1:0] exp_addr, cur_addr, maddr;
  logic [WL-1:0] exp_rd;
  int            starve, mcount;
  logic [WL-1:0] mq[$];
  // behavioural controller
  bit            c_act, c_busy;
  int            c_lat, c_left, c_widx, c_fwd, c_sent;
  // stimulus knobs
  int            rd_mode, push_prob;
  bit            force_busy, dir_push, dir_rd;
  logic [WL-1:0] dir_data;
  logic [AW-1:0] dir_addr, dir_rd_addr;
  // observation logs
  int            n_en, n_ack, n_rv, n_rdone, n_wdone;
  bit            rw_log[$];
  logic [AW-1:0] alog[$];
  logic [WL-1:0] wlog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no completion within cycle budget at %0t", name, $time);
  endtask

  task automatic reset_model();
    free = 1; exp_en = 0; exp_rw = 0; exp_rv = 0; exp_rdone = 0; exp_wdone = 0;
    cur_rw = 0; cur_addr = '0; exp_addr = '0; exp_rd = '0; maddr = '0;
    starve = 0; mcount = 0; mq.delete(); movf = 0;
    c_act = 0; c_busy = 0; force_busy = 0; dir_push = 0; dir_rd = 0;
    i_rd_req = 0; i_rd_addr = '0; i_wr_push = 0; i_wr_data = '0; i_wr_addr = '0;
    i_ctrl_rdata = '0; i_ctrl_valid = 0; i_ctrl_busy = 0;
  endtask

  task automatic clr_logs();
    n_en = 0; n_ack = 0; n_rv = 0; n_rdone = 0; n_wdone = 0;
    rw_log.delete(); alog.delete(); wlog.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_ack"},  32'(o_rd_ack), 0);
    chk({tag, "_rd_data"}, 32'(o_rd_data), 0);
    chk({tag, "_rd_valid"}, 32'(o_rd_valid), 0);
    chk({tag, "_rd_done"}, 32'(o_rd_done), 0);
    chk({tag, "_wr_full"}, 32'(o_wr_full), 0);
    chk({tag, "_wr_ovf"},  32'(o_wr_overflow), 0);
    chk({tag, "_wr_done"}, 32'(o_wr_done), 0);
    chk({tag, "_enable"},  32'(o_ctrl_enable), 0);
    chk({tag, "_rw"},      32'(o_ctrl_rw), 0);
    chk({tag, "_addr"},    32'(o_ctrl_addr), 0);
    chk({tag, "_wdata"},   32'(o_ctrl_wdata), 0);
  endtask

  // One clock: compare outputs, advance model/controller, drive next inputs.
  task automatic cycle();
    bit full_before, pick_wr, acked, started;
    @(posedge CLK); #1;
    chk("enable", 32'(o_ctrl_enable), 32'(exp_en));
    chk("rd_ack", 32'(o_rd_ack), 32'(exp_en && exp_rw));
    if (exp_en) begin
      chk("ctrl_rw", 32'(o_ctrl_rw), 32'(exp_rw));
      chk("ctrl_addr", 32'(o_ctrl_addr), 32'(exp_addr));
    end else if (!free) begin
      chk("rw_hold", 32'(o_ctrl_rw), 32'(cur_rw));
      chk("addr_hold", 32'(o_ctrl_addr), 32'(cur_addr));
    end
    chk("rd_valid", 32'(o_rd_valid), 32'(exp_rv));
    if (exp_rv) chk("rd_data", 32'(o_rd_data), 32'(exp_rd));
    chk("rd_done", 32'(o_rd_done), 32'(exp_rdone));
    chk("wr_done", 32'(o_wr_done), 32'(exp_wdone));
    if (o_ctrl_enable) begin n_en++; rw_log.push_back(o_ctrl_rw); alog.push_back(o_ctrl_addr); end
    if (o_rd_ack)   n_ack++;
    if (o_rd_valid) n_rv++;
    if (o_rd_done)  n_rdone++;
    if (o_wr_done)  n_wdone++;

    if (exp_rdone || exp_wdone) begin
      free = 1;
      if (exp_wdone) begin mcount = 0; mq.delete(); end
    end
    chk("wr_full", 32'(o_wr_full), 32'(mcount == BL));
    chk("wr_overflow", 32'(o_wr_overflow), 32'(movf));

    acked   = exp_en && exp_rw;
    started = exp_en;
    if (exp_en) begin
      free = 0; cur_rw = exp_rw; cur_addr = exp_addr;
      c_act = 1; c_busy = 1; c_lat = $urandom_range(1, 3);
      c_left = BL + (exp_rw ? int'($urandom_range(0, 2)) : 0);
      c_widx = 0; c_fwd = 0; c_sent = 0;
    end
    exp_en = 0; exp_rv = 0; exp_rdone = 0; exp_wdone = 0;

    i_ctrl_valid = 0;
    if (c_act && !started) begin
      if (c_lat > 0) c_lat--;
      else if (c_left > 0) begin
        if ($urandom_range(0, 3) != 0) begin
          i_ctrl_valid = 1; c_left--; c_sent++;
          if (cur_rw) begin
            i_ctrl_rdata = WL'($urandom);
            if (c_fwd < BL) begin exp_rv = 1; exp_rd = i_ctrl_rdata; c_fwd++; end
          end else begin
            chk("ctrl_wdata", 32'(o_ctrl_wdata), (c_widx < mq.size()) ? 32'(mq[c_widx]) : 32'bx);
            wlog.push_back(o_ctrl_wdata);
            c_widx++;
          end
        end
      end else begin
        c_act = 0; c_busy = 0;
        if (cur_rw) exp_rdone = 1; else exp_wdone = 1;
      end
    end
    i_ctrl_busy = c_busy || force_busy;

    if (acked) begin
      if (rd_mode == 2 || (rd_mode == 1 && $urandom_range(0, 1) == 1)) i_rd_addr = AW'($urandom);
      else i_rd_req = 0;
    end else if (rd_mode == 1 && !i_rd_req && $urandom_range(0, 3) == 0) begin
      i_rd_req = 1; i_rd_addr = AW'($urandom);
    end
    if (rd_mode == 2 && !i_rd_req) begin i_rd_req = 1; i_rd_addr = AW'($urandom); end
    if (dir_rd) begin i_rd_req = 1; i_rd_addr = dir_rd_addr; dir_rd = 0; end

    full_before = (mcount == BL);
    i_wr_push = 0;
    if (dir_push) begin
      i_wr_push = 1; i_wr_data = dir_data; i_wr_addr = dir_addr; dir_push = 0;
    end else if (int'($urandom_range(0, 99)) < push_prob) begin
      i_wr_push = 1; i_wr_data = WL'($urandom); i_wr_addr = AW'($urandom);
    end
    if (i_wr_push) begin
      if (mcount < BL) begin
        mq.push_back(i_wr_data); mcount++;
        if (mcount == BL) maddr = i_wr_addr;
      end else movf = 1;
    end

    // arbitration rule: the buffer only counts once its fill is registered
    if (free && !i_ctrl_busy && (i_rd_req || full_before)) begin
      pick_wr  = full_before && (!i_rd_req || starve >= SL);
      exp_en   = 1;
      exp_rw   = !pick_wr;
      exp_addr = pick_wr ? maddr : i_rd_addr;
      if (pick_wr) starve = 0;
      else if (full_before && starve < SL) starve++;
    end
  endtask

  task automatic push_word(input logic [WL-1:0] d, input logic [AW-1:0] a);
    dir_push = 1; dir_data = d; dir_addr = a;
    cycle();
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    do begin cycle(); n++; end
    while (!(free && !c_act && !i_rd_req && mcount < BL && !exp_en) && n < limit);
    if (n >= limit) timeout_fail(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST = 1; rd_mode = 0; push_prob = 0;
    reset_model(); clr_logs();
    #2 RST = 0;
    @(posedge CLK); #1;
    chk_zero("reset");
    @(posedge CLK); #1;
    RST = 1;

    // T1: single full write burst
    clr_logs();
    for (int i = 0; i < BL; i++) push_word(WL'(16'h1000 + i), 24'h000100);
    wait_idle(200, "t1_idle");
    chk("t1_en_cnt", 32'(n_en), 1);
    if (rw_log.size() > 0) chk("t1_rw", 32'(rw_log[0]), 0);
    if (alog.size() > 0) chk("t1_addr", 32'(alog[0]), 32'h000100);
    chk("t1_wdone", 32'(n_wdone), 1);
    chk("t1_wlen", 32'(wlog.size()), BL);
    for (int i = 0; i < wlog.size() && i < BL; i++) chk("t1_wdata", 32'(wlog[i]), 32'h1000 + i);

    // T2: single read burst, surplus controller strobes dropped
    clr_logs();
    dir_rd = 1; dir_rd_addr = 24'h012340;
    wait_idle(300, "t2_idle");
    chk("t2_ack_cnt", 32'(n_ack), 1);
    if (alog.size() > 0) chk("t2_addr", 32'(alog[0]), 32'h012340);
    chk("t2_rvalid_cnt", 32'(n_rv), BL);
    chk("t2_rdone", 32'(n_rdone), 1);

    // T3: continuous reads against a full buffer
    clr_logs();
    force_busy = 1;
    for (int i = 0; i < BL; i++) push_word(WL'(16'h3000 + i), 24'h000300);
    rd_mode = 2;
    cycle();
    force_busy = 0;
    begin
      int n = 0;
      while (rw_log.size() < 6 && n < 600) begin cycle(); n++; end
      if (n >= 600) timeout_fail("t3_grants");
    end
    rd_mode = 0;
    wait_idle(300, "t3_idle");
    for (int i = 0; i < 6 && i < rw_log.size(); i++) chk("t3_grant_rw", 32'(rw_log[i]), (i == 4) ? 0 : 1);

    // T5: controller busy in idle with both ports pending
    clr_logs();
    force_busy = 1;
    for (int i = 0; i < BL; i++) push_word(WL'(16'h5000 + i), 24'h000500);
    dir_rd = 1; dir_rd_addr = 24'h000777;
    repeat (10) cycle();
    chk("t5_no_enable", 32'(n_en), 0);
    force_busy = 0;
    wait_idle(400, "t5_idle");
    chk("t5_en_cnt", 32'(n_en), 2);
    if (rw_log.size() > 1) begin
      chk("t5_first_rd", 32'(rw_log[0]), 1);
      chk("t5_then_wr", 32'(rw_log[1]), 0);
    end

    // T4: overflow on push into a full buffer
    clr_logs();
    force_busy = 1;
    for (int i = 0; i < BL; i++) push_word(WL'(16'h2000 + i), 24'hABCDE0);
    push_word(16'hDEAD, 24'h111111);
    cycle();
    chk("t4_overflow", 32'(o_wr_overflow), 1);
    chk("t4_full", 32'(o_wr_full), 1);
    force_busy = 0;
    wait_idle(300, "t4_idle");
    if (alog.size() > 0) chk("t4_addr", 32'(alog[0]), 32'hABCDE0);
    chk("t4_wlen", 32'(wlog.size()), BL);
    for (int i = 0; i < wlog.size() && i < BL; i++) chk("t4_wdata", 32'(wlog[i]), 32'h2000 + i);
    chk("t4_ovf_sticky", 32'(o_wr_overflow), 1);

    // random traffic
    rd_mode = 1; push_prob = 30;
    repeat (1500) cycle();
    rd_mode = 0; push_prob = 0;
    while (mcount > 0 && mcount < BL) push_word(WL'($urandom), AW'($urandom));
    wait_idle(600, "rand_drain");

    // T6: reset in the middle of a write data phase
    clr_logs();
    for (int i = 0; i < BL; i++) push_word(WL'(16'h6000 + i), 24'h000600);
    begin
      int n = 0;
      while (!(c_act && !cur_rw && c_sent >= 3) && n < 200) begin cycle(); n++; end
      if (n >= 200) timeout_fail("t6_xfer");
    end
    RST = 0;
    reset_model();
    @(posedge CLK); #1;
    chk_zero("t6");
    @(posedge CLK); #1;
    RST = 1;
    repeat (4) cycle();

    rd_mode = 1; push_prob = 40;
    repeat (600) cycle();
    rd_mode = 0; push_prob = 0;
    while (mcount > 0 && mcount < BL) push_word(WL'($urandom), AW'($urandom));
    wait_idle(600, "final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
